signed_mul_add: RTL and testbench

Pipelined signed multiply-add that rebuilds a dividend from a divider result: dividend_o = quotient_i * divisor_i + remainder_i. It is the inverse datapath of the `division` block. It sits downstream of `division` as an in-design result checker and as the multiply path for reciprocal/scaling flows. It accepts one operand set per cycle, has fixed latency, and has no backpressure.

---
 rtl/signed_mul_add_pkg.sv | 20 ++
 rtl/signed_mul_add_if.sv | 26 ++
 rtl/signed_mul_add_stage.sv | 59 +++++
 rtl/signed_mul_add.sv | 100 ++++++++++
 tb/tb_signed_mul_add.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/signed_mul_add_pkg.sv
// Shared widths, latency helper and stage payload for the signed multiply-add.
// Benches and division checkers use mul_add_latency() to align results.
package mul_add_pkg;

    localparam int N_DEF = 20;
    localparam int M_DEF = 20;

    function automatic int mul_add_latency(input int m);
        return m + 2;
    endfunction

    typedef struct packed {
        logic                            valid;
        logic signed [N_DEF-1:0]         quot;
        logic signed [M_DEF-1:0]         divs;
        logic signed [M_DEF-1:0]         rem;
        logic signed [N_DEF+M_DEF-1:0]   acc;
    } mul_add_stage_t;

endpackage

// File: rtl/signed_mul_add_if.sv
// Operand/result bundle for signed_mul_add; fixed latency, no backpressure.
// The master side drives operands, the slave side returns the rebuilt dividend.
interface signed_mul_add_if #(
    parameter int N = 20,
    parameter int M = 20
);

    logic                  valid_i;
    logic signed [N-1:0]   quotient_i;
    logic signed [M-1:0]   divisor_i;
    logic signed [M-1:0]   remainder_i;
    logic                  valid_o;
    logic signed [N+M-1:0] dividend_o;
    logic                  overflow_o;

    modport master (
        output valid_i, quotient_i, divisor_i, remainder_i,
        input  valid_o, dividend_o, overflow_o
    );

    modport slave (
        input  valid_i, quotient_i, divisor_i, remainder_i,
        output valid_o, dividend_o, overflow_o
    );

endinterface

// File: rtl/signed_mul_add_stage.sv
// One registered radix-2 partial-product step for divisor bit BIT.
// The MSB stage carries weight -2^(M-1) and therefore subtracts.
module mul_add_stage #(
    parameter int N      = 20,
    parameter int M      = 20,
    parameter int BIT    = 0,
    parameter bit IS_MSB = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic signed [N-1:0]   quot_i,
    input  logic signed [M-1:0]   divs_i,
    input  logic signed [M-1:0]   rem_i,
    input  logic signed [N+M-1:0] acc_i,
    output logic signed [N-1:0]   quot_o,
    output logic signed [M-1:0]   divs_o,
    output logic signed [M-1:0]   rem_o,
    output logic signed [N+M-1:0] acc_o
);

    localparam int W = N + M;

    typedef struct packed {
        logic signed [N-1:0] quot;
        logic signed [M-1:0] divs;
        logic signed [M-1:0] rem;
        logic signed [W-1:0] acc;
    } payload_t;

    payload_t            st_d;
    payload_t            st_q;
    logic signed [W-1:0] pp;

    always_comb begin
        pp      = {{M{quot_i[N-1]}}, quot_i} <<< BIT;
        st_d      = '0;
        st_d.quot = quot_i;
        st_d.divs = divs_i;
        st_d.rem  = rem_i;
        st_d.acc  = acc_i;
        if (divs_i[BIT]) begin
            st_d.acc = IS_MSB ? acc_i - pp : acc_i + pp;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign quot_o = st_q.quot;
    assign divs_o = st_q.divs;
    assign rem_o  = st_q.rem;
    assign acc_o  = st_q.acc;

endmodule

// File: rtl/signed_mul_add.sv
// Pipelined quotient*divisor+remainder: input register, M shift-add stages,
// then the remainder add and overflow flag in a final register (latency M+2).
module signed_mul_add
    import mul_add_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input logic              clk_i,
    input logic              rst_i,
    signed_mul_add_if.slave  bus
);

    localparam int W = N + M;

    typedef struct packed {
        logic signed [N-1:0] quot;
        logic signed [M-1:0] divs;
        logic signed [M-1:0] rem;
    } in_t;

    in_t                 in_d;
    in_t                 in_q;
    logic [M:0]          vld_d;
    logic [M:0]          vld_q;
    logic signed [W-1:0] dividend_d;
    logic signed [W-1:0] dividend_q;
    logic                ovf_d;
    logic                ovf_q;
    logic                vo_d;
    logic                vo_q;
    logic signed [W-1:0] res;

    logic signed [N-1:0] quot_s [M+1];
    logic signed [M-1:0] divs_s [M+1];
    logic signed [M-1:0] rem_s  [M+1];
    logic signed [W-1:0] acc_s  [M+1];

    assign quot_s[0] = in_q.quot;
    assign divs_s[0] = in_q.divs;
    assign rem_s[0]  = in_q.rem;
    assign acc_s[0]  = '0;

    for (genvar k = 1; k <= M; k++) begin : g_stage
        mul_add_stage #(
            .N      (N),
            .M      (M),
            .BIT    (k - 1),
            .IS_MSB (k == M)
        ) u_stage (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .quot_i (quot_s[k-1]),
            .divs_i (divs_s[k-1]),
            .rem_i  (rem_s[k-1]),
            .acc_i  (acc_s[k-1]),
            .quot_o (quot_s[k]),
            .divs_o (divs_s[k]),
            .rem_o  (rem_s[k]),
            .acc_o  (acc_s[k])
        );
    end

    always_comb begin
        in_d.quot  = bus.quotient_i;
        in_d.divs  = bus.divisor_i;
        in_d.rem   = bus.remainder_i;
        vld_d      = {vld_q[M-1:0], bus.valid_i};
        res        = acc_s[M] + {{N{rem_s[M][M-1]}}, rem_s[M]};
        dividend_d = dividend_q;
        ovf_d      = ovf_q;
        vo_d       = vld_q[M];
        // Results only move on a valid slot; idle slots hold the last value.
        if (vld_q[M]) begin
            dividend_d = res;
            ovf_d      = !((&res[W-1:N-1]) || (~|res[W-1:N-1]));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_q       <= '0;
            vld_q      <= '0;
            dividend_q <= '0;
            ovf_q      <= 1'b0;
            vo_q       <= 1'b0;
        end else begin
            in_q       <= in_d;
            vld_q      <= vld_d;
            dividend_q <= dividend_d;
            ovf_q      <= ovf_d;
            vo_q       <= vo_d;
        end
    end

    assign bus.valid_o    = vo_q;
    assign bus.dividend_o = dividend_q;
    assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_signed_mul_add.sv
// Directed and division-derived vectors for signed_mul_add with a tagged
// scoreboard that also checks idle cycles, output hold and async reset.
module tb_signed_mul_add;
    import mul_add_pkg::*;

    localparam int N   = 20;
    localparam int M   = 20;
    localparam int W   = N + M;
    localparam int LAT = mul_add_latency(M);

    logic clk;
    logic rst;

    signed_mul_add_if #(.N(N), .M(M)) bus ();

    signed_mul_add #(.N(N), .M(M)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int                  tag;
        logic signed [W-1:0] div;
        logic                ovf;
    } exp_t;

    typedef struct {
        logic signed [N-1:0] q;
        logic signed [M-1:0] d;
        logic signed [M-1:0] r;
        logic signed [W-1:0] div;
        logic                ovf;
    } vec_t;

    exp_t                sb [$];
    vec_t                vt [8];
    int                  n_cmp;
    int                  n_bad;
    int                  cyc;
    int                  n_vo;
    logic signed [W-1:0] last_div;
    logic                last_ovf;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    // Output monitor: one step per rising edge, sampled 1ns after it.
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst) begin
                if (sb.size() > 0 && sb[0].tag == cyc) begin
                    e = sb.pop_front();
                    chk("valid_o", bus.valid_o, 1);
                    chk("dividend_o", bus.dividend_o, e.div);
                    chk("overflow_o", bus.overflow_o, e.ovf);
                    last_div = e.div;
                    last_ovf = e.ovf;
                    n_vo++;
                end else begin
                    chk("valid_o idle", bus.valid_o, 0);
                    chk("dividend_o hold", bus.dividend_o, last_div);
                    chk("overflow_o hold", bus.overflow_o, last_ovf);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic signed [N-1:0] q,
                         input logic signed [M-1:0] d,
                         input logic signed [M-1:0] r,
                         input logic signed [W-1:0] e, input logic eo);
        exp_t x;
        @(negedge clk);
        bus.valid_i     = v;
        bus.quotient_i  = q;
        bus.divisor_i   = d;
        bus.remainder_i = r;
        if (v) begin
            x.tag = cyc + LAT;
            x.div = e;
            x.ovf = eo;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic drain(input string nm);
        idle(LAT + 4);
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        int base;
        int dv;
        int dd;
        logic signed [N-1:0] q;
        logic signed [M-1:0] d;
        logic signed [M-1:0] r;

        n_cmp           = 0;
        n_bad           = 0;
        cyc             = 0;
        n_vo            = 0;
        last_div        = '0;
        last_ovf        = 1'b0;
        rst             = 1'b1;
        bus.valid_i     = 1'b0;
        bus.quotient_i  = '0;
        bus.divisor_i   = '0;
        bus.remainder_i = '0;

        #2;
        chk("rst valid_o", bus.valid_o, 0);
        chk("rst dividend_o", bus.dividend_o, 0);
        chk("rst overflow_o", bus.overflow_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 7, 3, 2, 23, 1'b0);
        drain("single drain");

        vt[0] = '{q: 7, d: 3, r: 2, div: 23, ovf: 1'b0};
        vt[1] = '{q: -7, d: 3, r: -1, div: -22, ovf: 1'b0};
        vt[2] = '{q: 0, d: -5, r: 4, div: 4, ovf: 1'b0};
        vt[3] = '{q: -524288, d: -524288, r: 0,
                  div: 40'sh40_0000_0000, ovf: 1'b1};
        vt[4] = '{q: -524288, d: 1, r: 0, div: -524288, ovf: 1'b0};
        vt[5] = '{q: -524288, d: -524288, r: 524287,
                  div: 40'sh40_0007_FFFF, ovf: 1'b1};
        vt[6] = '{q: 5, d: -524288, r: 0, div: -2621440, ovf: 1'b1};
        vt[7] = '{q: 3, d: 7, r: -10, div: 11, ovf: 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].q, vt[i].d, vt[i].r, vt[i].div, vt[i].ovf);
        end
        drain("table drain");

        base = n_vo;
        for (int i = 0; i < 1000; i++) begin
            dv = int'($urandom_range(1048575, 0)) - 524288;
            do begin
                dd = int'($urandom_range(1048575, 0)) - 524288;
            end while (dd == 0 || (dd == -1 && dv == -524288));
            q = N'(dv / dd);
            d = M'(dd);
            r = M'(dv % dd);
            drive(1'b1, q, d, r, W'(dv), 1'b0);
        end
        drain("random drain");
        chk("random count", n_vo - base, 1000);

        drive(1'b1, 1, 1, 0, 1, 1'b0);
        drive(1'b0, 2, 1, 0, 0, 1'b0);
        drive(1'b1, 3, 1, 0, 3, 1'b0);
        drive(1'b1, 4, 1, 0, 4, 1'b0);
        drive(1'b0, 5, 1, 0, 0, 1'b0);
        drain("gap drain");

        base = n_vo;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, N'(i + 10), 3, 0, W'((i + 10) * 3), 1'b0);
        end
        idle(3);
        @(negedge clk);
        rst      = 1'b1;
        sb.delete();
        last_div = '0;
        last_ovf = 1'b0;
        #1;
        chk("async valid_o", bus.valid_o, 0);
        chk("async dividend_o", bus.dividend_o, 0);
        chk("async overflow_o", bus.overflow_o, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(LAT + 4);
        chk("flushed count", n_vo - base, 0);
        drive(1'b1, 2, 2, 1, 5, 1'b0);
        drain("post-reset drain");
        chk("post-reset count", n_vo - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
